pipe_ctrl_unit: RTL and testbench

Next-generation pipelined control unit. Decodes the 5-bit func of the instruction in IF/ID and registers the datapath controls into the ID/EX stage. Adds load-use stall detection, branch/jump flush, and a parametrised hardware return-address stack for call/ret. Sits between the IF/ID register and the EX stage; drives PC select, IF/ID stall and flush.

---
 rtl/pipe_ctrl_unit.sv | 197 +++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined control unit between the IF/ID register and EX.
// Decodes func, registers the EX-stage controls, detects load-use and flag
// hazards, redirects on branch/jump/call/ret and keeps a return-address stack.
// Optional feature macro: FLAG_FWD_EN (forward EX flags into branch decisions
// instead of stalling on a flag hazard).
module pipe_ctrl_unit #(
  parameter int STACK_DEPTH = 8,
  parameter int PC_W        = 12,
  parameter int RA_W        = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      func,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [PC_W-1:0] id_ret_addr,
  input  logic            Z,
  input  logic            C,
  input  logic            ex_z,
  input  logic            ex_c,
  output logic            ld_pc,
  output logic [1:0]      pc_sel,
  output logic [PC_W-1:0] ret_addr,
  output logic            stall,
  output logic            flush_ifid,
  output logic            ex_reg_write_en,
  output logic            ex_sel1_alu_in,
  output logic            ex_sel2_alu_in,
  output logic            ex_ldzero,
  output logic            ex_ldcarry,
  output logic            ex_mem_write_en,
  output logic            ex_mem_read,
  output logic            ex_sel_data_rf_write,
  output logic [RA_W-1:0] ex_rd,
  output logic            stack_full,
  output logic            stack_empty,
  output logic            stack_err
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic reg_write;
    logic sel1;
    logic sel2;
    logic ldzero;
    logic ldcarry;
    logic mem_write;
    logic mem_read;
    logic sel_data;
  } ctrl_t;

  ctrl_t            dec, ctrl_d, ctrl_q;
  logic [RA_W-1:0]  ex_rd_d, ex_rd_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             err_d, err_q;
  logic [PC_W-1:0]  stack_mem_q [STACK_DEPTH];

  logic is_zbr, is_cbr, is_jump, is_call, is_ret, is_illegal;
  logic z_eff, c_eff, br_taken;
  logic load_use, flag_haz;
  logic push, pop, err_set;
  logic [CNT_W-1:0] top_ptr;

  // Instruction decode into EX controls and control-flow class.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dec        = '0;
    is_zbr     = 1'b0;
    is_cbr     = 1'b0;
    is_jump    = 1'b0;
    is_call    = 1'b0;
    is_ret     = 1'b0;
    is_illegal = 1'b0;
    casez (func)
      5'b00???: begin dec.ldzero = 1'b1; dec.ldcarry = 1'b1; dec.sel_data = 1'b1; dec.reg_write = 1'b1; end
      5'b01???: begin dec.ldzero = 1'b1; dec.ldcarry = 1'b1; dec.sel_data = 1'b1; dec.reg_write = 1'b1; dec.sel1 = 1'b1; end
      5'b110??: begin dec.ldzero = 1'b1; dec.ldcarry = 1'b1; dec.sel_data = 1'b1; dec.reg_write = 1'b1; dec.sel2 = 1'b1; end
      5'b10000: begin dec.sel1 = 1'b1; dec.mem_read = 1'b1; dec.reg_write = 1'b1; end
      5'b10001: begin dec.sel1 = 1'b1; dec.mem_write = 1'b1; end
      5'b101??: begin is_zbr = ~func[1]; is_cbr = func[1]; end
      5'b11100: is_jump = 1'b1;
      5'b11101: is_call = 1'b1;
      5'b11110: is_ret  = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

`ifdef FLAG_FWD_EN
  // Flags still being produced in EX are forwarded; no flag stall exists.
  assign z_eff    = ctrl_q.ldzero  ? ex_z : Z;
  assign c_eff    = ctrl_q.ldcarry ? ex_c : C;
  assign flag_haz = 1'b0;
`else
  // EX flag outputs are not consulted; a branch on an in-flight flag waits.
  logic unused_ex_flags;
  assign unused_ex_flags = ex_z ^ ex_c;
  assign z_eff    = Z;
  assign c_eff    = C;
  assign flag_haz = id_valid & ((is_zbr & ctrl_q.ldzero) | (is_cbr & ctrl_q.ldcarry));
`endif

  // func[1] picks Z or C, func[0] inverts the condition.
  assign br_taken = (is_zbr | is_cbr) & ((func[1] ? c_eff : z_eff) ^ func[0]);
  assign load_use = id_valid & ctrl_q.mem_read & ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));

  assign stack_full  = (count_q == CNT_W'(STACK_DEPTH));
  assign stack_empty = (count_q == '0);
  assign top_ptr     = count_q - CNT_W'(1);
  assign ret_addr    = stack_mem_q[top_ptr[IDX_W-1:0]];

  // Hazard priority and PC redirect selection; all forced quiet during reset.
  always_comb begin
    ld_pc      = 1'b0;
    pc_sel     = 2'b00;
    stall      = 1'b0;
    flush_ifid = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    if (!rst) begin
      if (load_use || flag_haz) begin
        stall = 1'b1;
      end else begin
        ld_pc = 1'b1;
        if (id_valid) begin
          if (is_illegal) begin
            err_set = 1'b1;
          end else if (is_jump || br_taken) begin
            pc_sel     = 2'b01;
            flush_ifid = 1'b1;
          end else if (is_call) begin
            pc_sel     = 2'b01;
            flush_ifid = 1'b1;
            if (stack_full) err_set = 1'b1;
            else            push    = 1'b1;
          end else if (is_ret) begin
            if (stack_empty) begin
              err_set = 1'b1;
            end else begin
              pc_sel     = 2'b10;
              flush_ifid = 1'b1;
              pop        = 1'b1;
            end
          end
        end
      end
    end
  end

  // Next-state for EX controls, stack count and sticky error.
  always_comb begin
    ctrl_d  = (id_valid && !stall) ? dec   : '0;
    ex_rd_d = (id_valid && !stall) ? id_rd : '0;
    count_d = count_q;
    if (push)     count_d = count_q + CNT_W'(1);
    else if (pop) count_d = count_q - CNT_W'(1);
    err_d = err_q | err_set;
  end

  // State registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      ex_rd_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      ex_rd_q <= ex_rd_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Return-address storage; the count alone says which entries are live.
  // NOTE: the stack array is deliberately not reset; resetting count empties it.
  always_ff @(posedge clk) begin
    if (push) stack_mem_q[count_q[IDX_W-1:0]] <= id_ret_addr;
  end

  assign ex_reg_write_en      = ctrl_q.reg_write;
  assign ex_sel1_alu_in       = ctrl_q.sel1;
  assign ex_sel2_alu_in       = ctrl_q.sel2;
  assign ex_ldzero            = ctrl_q.ldzero;
  assign ex_ldcarry           = ctrl_q.ldcarry;
  assign ex_mem_write_en      = ctrl_q.mem_write;
  assign ex_mem_read          = ctrl_q.mem_read;
  assign ex_sel_data_rf_write = ctrl_q.sel_data;
  assign ex_rd                = ex_rd_q;
  assign stack_err            = err_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed testbench for pipe_ctrl_unit (STACK_DEPTH=8, PC_W=12, RA_W=3).
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  func;
  logic        id_valid;
  logic [2:0]  id_rs1, id_rs2, id_rd;
  logic [11:0] id_ret_addr;
  logic        Z, C, ex_z, ex_c;
  logic        ld_pc, stall, flush_ifid;
  logic [1:0]  pc_sel;
  logic [11:0] ret_addr;
  logic        ex_reg_write_en, ex_sel1_alu_in, ex_sel2_alu_in, ex_ldzero, ex_ldcarry;
  logic        ex_mem_write_en, ex_mem_read, ex_sel_data_rf_write;
  logic [2:0]  ex_rd;
  logic        stack_full, stack_empty, stack_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.STACK_DEPTH(8), .PC_W(12), .RA_W(3)) dut (
    .clk(clk), .rst(rst), .func(func), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ret_addr(id_ret_addr),
    .Z(Z), .C(C), .ex_z(ex_z), .ex_c(ex_c),
    .ld_pc(ld_pc), .pc_sel(pc_sel), .ret_addr(ret_addr), .stall(stall), .flush_ifid(flush_ifid),
    .ex_reg_write_en(ex_reg_write_en), .ex_sel1_alu_in(ex_sel1_alu_in),
    .ex_sel2_alu_in(ex_sel2_alu_in), .ex_ldzero(ex_ldzero), .ex_ldcarry(ex_ldcarry),
    .ex_mem_write_en(ex_mem_write_en), .ex_mem_read(ex_mem_read),
    .ex_sel_data_rf_write(ex_sel_data_rf_write), .ex_rd(ex_rd),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, then let combinational outputs settle.
  task automatic drive(input logic [4:0] f, input logic v, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [2:0] rd, input logic [11:0] ra);
    func = f; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ret_addr = ra;
    #1;
  endtask

  // Combinational redirect outputs in one call.
  task automatic check_pc(input string tag, input logic l, input logic [1:0] sel,
                          input logic s, input logic f);
    check({tag, "_ld_pc"}, ld_pc, l);
    check({tag, "_pc_sel"}, pc_sel, sel);
    check({tag, "_stall"}, stall, s);
    check({tag, "_flush"}, flush_ifid, f);
  endtask

  initial begin
    rst = 1'b1; Z = 1'b0; C = 1'b0; ex_z = 1'b0; ex_c = 1'b0;
    // Jump presented during reset must not redirect.
    drive(5'b11100, 1'b1, 3'd0, 3'd0, 3'd0, 12'h000);
    check_pc("rst", 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    check("rst_ex_rw", ex_reg_write_en, 1'b0);
    check("rst_empty", stack_empty, 1'b1);
    check("rst_full", stack_full, 1'b0);
    check("rst_err", stack_err, 1'b0);
    rst = 1'b0;

    // ALU reg/reg.
    drive(5'b00000, 1'b1, 3'd5, 3'd6, 3'd2, 12'h000);
    check_pc("alu", 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    check("alu_rw", ex_reg_write_en, 1'b1);
    check("alu_ldz", ex_ldzero, 1'b1);
    check("alu_ldc", ex_ldcarry, 1'b1);
    check("alu_sd", ex_sel_data_rf_write, 1'b1);
    check("alu_s1", ex_sel1_alu_in, 1'b0);
    check("alu_rd", ex_rd, 3'd2);

    // Load to r3.
    drive(5'b10000, 1'b1, 3'd0, 3'd0, 3'd3, 12'h000);
    check_pc("ld", 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    check("ld_mr", ex_mem_read, 1'b1);
    check("ld_sd", ex_sel_data_rf_write, 1'b0);
    check("ld_s1", ex_sel1_alu_in, 1'b1);
    check("ld_rd", ex_rd, 3'd3);

    // ALU reading r3: one-cycle load-use stall, then issue.
    drive(5'b01000, 1'b1, 3'd3, 3'd0, 3'd4, 12'h000);
    check_pc("lu", 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    check("lu_bubble_rw", ex_reg_write_en, 1'b0);
    check("lu_bubble_mr", ex_mem_read, 1'b0);
    check("lu_bubble_rd", ex_rd, 3'd0);
    #1;
    check_pc("lu2", 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    check("lu2_s1", ex_sel1_alu_in, 1'b1);
    check("lu2_rw", ex_reg_write_en, 1'b1);
    check("lu2_rd", ex_rd, 3'd4);

    // Immediate ALU form.
    drive(5'b11000, 1'b1, 3'd0, 3'd0, 3'd1, 12'h000);
    tick();
    check("imm_s2", ex_sel2_alu_in, 1'b1);
    check("imm_s1", ex_sel1_alu_in, 1'b0);

    // Store clears ldzero in EX so branches below see no flag hazard.
    drive(5'b10001, 1'b1, 3'd0, 3'd0, 3'd0, 12'h000);
    tick();
    check("st_mw", ex_mem_write_en, 1'b1);
    check("st_rw", ex_reg_write_en, 1'b0);
    check("st_ldz", ex_ldzero, 1'b0);

    Z = 1'b1;
    drive(5'b10100, 1'b1, 3'd0, 3'd0, 3'd0, 12'h000);
    check_pc("bz_t", 1'b1, 2'b01, 1'b0, 1'b1);
    tick();
    check("bz_mw", ex_mem_write_en, 1'b0);
    Z = 1'b0;
    #1;
    check_pc("bz_nt", 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    C = 1'b0;
    drive(5'b10111, 1'b1, 3'd0, 3'd0, 3'd0, 12'h000);
    check_pc("bnc_t", 1'b1, 2'b01, 1'b0, 1'b1);
    tick();

    // Call / call / ret / ret.
    drive(5'b11101, 1'b1, 3'd0, 3'd0, 3'd0, 12'h010);
    check_pc("call1", 1'b1, 2'b01, 1'b0, 1'b1);
    tick();
    check("call1_empty", stack_empty, 1'b0);
    drive(5'b11101, 1'b1, 3'd0, 3'd0, 3'd0, 12'h020);
    tick();
    drive(5'b11110, 1'b1, 3'd0, 3'd0, 3'd0, 12'h000);
    check_pc("ret1", 1'b1, 2'b10, 1'b0, 1'b1);
    check("ret1_addr", ret_addr, 12'h020);
    tick();
    check("ret2_addr", ret_addr, 12'h010);
    check("ret2_sel", pc_sel, 2'b10);
    tick();
    check("ret2_empty", stack_empty, 1'b1);
    check("ret2_err", stack_err, 1'b0);

    // Invalid slot: no redirect, bubble.
    drive(5'b11110, 1'b0, 3'd0, 3'd0, 3'd0, 12'h000);
    check_pc("inv", 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    check("inv_empty", stack_empty, 1'b1);

    // Nine calls into an eight-deep stack.
    for (int i = 0; i < 9; i++) begin
      drive(5'b11101, 1'b1, 3'd0, 3'd0, 3'd0, 12'h100 + 12'(i));
      check(i == 8 ? "call9_sel" : "calln_sel", pc_sel, 2'b01);
      tick();
      if (i == 7) begin
        check("call8_full", stack_full, 1'b1);
        check("call8_err", stack_err, 1'b0);
      end
    end
    check("call9_full", stack_full, 1'b1);
    check("call9_err", stack_err, 1'b1);
    check("call9_top", ret_addr, 12'h107);
    for (int i = 0; i < 8; i++) begin
      drive(5'b11110, 1'b1, 3'd0, 3'd0, 3'd0, 12'h000);
      check("pop_addr", ret_addr, 12'h107 - 12'(i));
      tick();
    end
    check("pop_empty", stack_empty, 1'b1);
    #1;
    check_pc("underflow", 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    check("underflow_err", stack_err, 1'b1);

    // Reset clears error and discards stack contents.
    rst = 1'b1;
    drive(5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 12'h000);
    tick();
    rst = 1'b0;
    check("rst2_err", stack_err, 1'b0);
    drive(5'b11101, 1'b1, 3'd0, 3'd0, 3'd0, 12'h055);
    tick();
    check("mid_empty0", stack_empty, 1'b0);
    rst = 1'b1;
    drive(5'b00000, 1'b0, 3'd0, 3'd0, 3'd0, 12'h000);
    tick();
    rst = 1'b0;
    check("mid_empty1", stack_empty, 1'b1);

    // Illegal func.
    drive(5'b10010, 1'b1, 3'd0, 3'd0, 3'd5, 12'h000);
    check_pc("ill", 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    check("ill_err", stack_err, 1'b1);
    check("ill_rw", ex_reg_write_en, 1'b0);
    check("ill_mr", ex_mem_read, 1'b0);

    // Flag hazard: flag-writing ALU op, then branch on Z.
    drive(5'b00001, 1'b1, 3'd0, 3'd0, 3'd1, 12'h000);
    tick();
    Z = 1'b0; ex_z = 1'b1;
    drive(5'b10100, 1'b1, 3'd0, 3'd0, 3'd0, 12'h000);
`ifdef FLAG_FWD_EN
    check_pc("fh_fwd", 1'b1, 2'b01, 1'b0, 1'b1);
    tick();
`else
    check_pc("fh", 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    check("fh_bubble", ex_ldzero, 1'b0);
    #1;
    check_pc("fh2", 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
`endif
    id_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
